dcache_stall_ctrl: RTL and testbench
====================================

DCACHE_STALL_CTRL -- requirements
Module: dcache_stall_ctrl

Interface
REQ-001 The block SHALL have exactly these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cpu_addr_i  in  32  byte address from EX/MEM stage.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  stall to all pipeline registers (drives their stall_i).
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line writeback, 0 = line fetch.
- mem_addr_o  out  32  line-aligned memory address.
- mem_data_o  out  256  writeback line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
REQ-002 The block SHALL have no parameters; geometry is fixed as below.

Function
REQ-003 Cache SHALL be direct-mapped, 32 lines x 256 bits, write-back, write-allocate; per line: valid, dirty, 22-bit tag.
REQ-004 Address split SHALL be tag = addr[31:10], index = addr[9:5], word = addr[4:2]; addr[1:0] ignored.
REQ-005 Request SHALL be cpu_MemRead_i | cpu_MemWrite_i; hit = valid[index] & tag match.
REQ-006 FSM states SHALL be IDLE, WRITEBACK, REFILL, DONE.
REQ-007 IDLE: on no request or hit, stay IDLE; on miss with dirty victim -> WRITEBACK; on miss with clean/invalid victim -> REFILL.
REQ-008 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; on mem_ack_i -> REFILL.
REQ-009 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i install mem_data_i, valid=1, dirty=0, tag=cpu tag -> DONE.
REQ-010 DONE: one cycle, no memory request -> IDLE, where the access then completes as a hit.
REQ-011 mem_enable_o and address/data SHALL hold stable until mem_ack_i; in IDLE and DONE mem_enable_o=0, mem_write_o=0.
REQ-012 cpu_stall_o SHALL be combinational: 1 in IDLE on request & miss, 1 in WRITEBACK, REFILL, DONE; 0 in IDLE with no request or hit.
REQ-013 Read hit latency SHALL be zero cycles: cpu_data_o = selected word combinationally; cpu_data_o = 0 when no read hit in IDLE.
REQ-014 Write hit SHALL update the selected 32-bit word and set dirty at the rising edge of the same cycle.
REQ-015 MemRead and MemWrite both high SHALL be treated as a write; cpu_data_o shows the pre-write word.
REQ-016 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-017 Request inputs SHALL be sampled only in IDLE; the pipeline holds them stable while stalled.

Reset
REQ-018 rst_i high at a rising edge SHALL force IDLE, clear all valid and dirty bits, and abort any pending memory request.
REQ-019 During and after reset: cpu_stall_o=0 (no request), mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
REQ-020 Tag and data arrays need not be reset.

Verification
REQ-021 Cold load 0x0000_0404 -> stall; REFILL mem_addr_o=0x0000_0400; ack with word1=0xDEAD_BEEF -> DONE, then cpu_data_o=0xDEAD_BEEF, stall 0.
REQ-022 Store 0x1234_5678 to 0x0000_0404 after REQ-021 -> no stall, line dirty; load same address returns 0x1234_5678 with zero latency.
REQ-023 Load 0x0000_0804 (same index 0, new tag) after REQ-022 -> WRITEBACK mem_addr_o=0x0000_0400 with word1=0x1234_5678, then REFILL 0x0000_0800.
REQ-024 Delay mem_ack_i 10 cycles in REFILL -> mem_enable_o, mem_addr_o and cpu_stall_o held constant for all 10 cycles.
REQ-025 Assert rst_i mid-WRITEBACK -> next cycle IDLE, mem_enable_o=0; reload of 0x0000_0404 misses.
REQ-026 Spurious mem_ack_i in IDLE with no request -> no state or array change.

Source files
------------

// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped write-back data cache controller with pipeline stall.
// 32 lines x 256 bits, FSM sequences victim writeback and line refill.
module dcache_stall_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [255:0] data_q [32];
  logic [21:0]  tag_q  [32];
  logic [31:0]  valid_q;
  logic [31:0]  dirty_q;

  logic [21:0]  tag;
  logic [4:0]   idx;
  logic [2:0]   word;
  logic [7:0]   bit_off;
  logic         req;
  logic         hit;
  logic         wr_hit;
  logic         rd_hit;
  logic         fill;
  logic [255:0] line;
  logic [21:0]  line_tag;
  logic         unused_ok;

  assign tag       = cpu_addr_i[31:10];
  assign idx       = cpu_addr_i[9:5];
  assign word      = cpu_addr_i[4:2];
  assign bit_off   = {word, 5'b0};
  assign unused_ok = ^cpu_addr_i[1:0];

  assign line     = data_q[idx];
  assign line_tag = tag_q[idx];
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit      = valid_q[idx] & (line_tag == tag);

  // Accesses complete only from IDLE; a combined read/write acts as a write
  assign wr_hit = (state_q == IDLE) & cpu_MemWrite_i & hit;
  assign rd_hit = (state_q == IDLE) & cpu_MemRead_i & hit;
  assign fill   = (state_q == REFILL) & mem_ack_i;

  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = 32'h0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 256'h0;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          cpu_stall_o = 1'b1;
          state_d     = dirty_q[idx] ? WRITEBACK : REFILL;
        end
        if (rd_hit) cpu_data_o = line[bit_off +: 32];
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, idx, 5'b0};
        mem_data_o   = line;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, 5'b0};
        if (mem_ack_i) state_d = DONE;
      end
      DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output, even before the state register clears
    if (rst_i) begin
      cpu_stall_o  = 1'b0;
      cpu_data_o   = 32'h0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'h0;
      mem_data_o   = 256'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 32'h0;
      dirty_q <= 32'h0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill) begin
        data_q[idx] <= mem_data_i;
        tag_q[idx]  <= tag;
      end else if (wr_hit) begin
        data_q[idx][bit_off +: 32] <= cpu_data_i;
      end
    end
  end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl.
// Drives and samples at the falling edge; the DUT updates on the rising edge.
module tb_dcache_stall_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_run  = 0;
  int n_fail = 0;

  logic [255:0] line1;
  logic [255:0] line2;

  always #5 clk_i = ~clk_i;

  dcache_stall_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i          = 1'b1;
    cpu_addr_i     = 32'h0;
    cpu_data_i     = 32'h0;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    mem_data_i     = 256'h0;
    mem_ack_i      = 1'b0;
    line1          = 256'h0;
    line1[63:32]   = 32'hDEAD_BEEF;
    line1[95:64]   = 32'h2222_2222;
    line2          = 256'h0;
    line2[31:0]    = 32'h5555_0000;
    line2[63:32]   = 32'hCAFE_F00D;

    repeat (2) nxt();
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_en", mem_enable_o, 0);
    chk("rst_wr", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mdata", mem_data_o, 0);
    chk("rst_cdata", cpu_data_o, 0);
    rst_i = 1'b0;

    // cold load 0x404
    cpu_addr_i    = 32'h0000_0404;
    cpu_MemRead_i = 1'b1;
    #1;
    chk("cold_stall", cpu_stall_o, 1);
    chk("cold_en_idle", mem_enable_o, 0);
    nxt();
    chk("rf1_en", mem_enable_o, 1);
    chk("rf1_wr", mem_write_o, 0);
    chk("rf1_addr", mem_addr_o, 32'h0000_0400);
    chk("rf1_stall", cpu_stall_o, 1);
    mem_data_i = line1;
    mem_ack_i  = 1'b1;
    nxt();
    mem_ack_i = 1'b0;
    chk("done_stall", cpu_stall_o, 1);
    chk("done_en", mem_enable_o, 0);
    nxt();
    chk("hit_stall", cpu_stall_o, 0);
    chk("hit_data", cpu_data_o, 32'hDEAD_BEEF);

    // store hit, then zero-latency load
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b1;
    cpu_data_i     = 32'h1234_5678;
    #1;
    chk("st_stall", cpu_stall_o, 0);
    chk("st_cdata", cpu_data_o, 0);
    nxt();
    cpu_MemWrite_i = 1'b0;
    cpu_MemRead_i  = 1'b1;
    #1;
    chk("ld_st_data", cpu_data_o, 32'h1234_5678);
    chk("ld_st_stall", cpu_stall_o, 0);
    cpu_addr_i = 32'h0000_0408;
    #1;
    chk("ld_w2_data", cpu_data_o, 32'h2222_2222);

    // spurious ack while idle
    cpu_addr_i    = 32'h0000_0404;
    cpu_MemRead_i = 1'b0;
    mem_data_i    = {8{32'hFFFF_FFFF}};
    mem_ack_i     = 1'b1;
    nxt();
    mem_ack_i = 1'b0;
    chk("sp_en", mem_enable_o, 0);
    chk("sp_stall", cpu_stall_o, 0);
    cpu_MemRead_i = 1'b1;
    #1;
    chk("sp_data", cpu_data_o, 32'h1234_5678);
    chk("sp_hit", cpu_stall_o, 0);

    // dirty eviction by 0x804
    cpu_addr_i = 32'h0000_0804;
    #1;
    chk("ev_stall", cpu_stall_o, 1);
    nxt();
    chk("wb_en", mem_enable_o, 1);
    chk("wb_wr", mem_write_o, 1);
    chk("wb_addr", mem_addr_o, 32'h0000_0400);
    chk("wb_w1", mem_data_o[63:32], 32'h1234_5678);
    chk("wb_w0", mem_data_o[31:0], 32'h0);
    nxt();
    chk("wb_hold_addr", mem_addr_o, 32'h0000_0400);
    chk("wb_hold_en", mem_enable_o, 1);
    mem_ack_i = 1'b1;
    nxt();
    mem_ack_i = 1'b0;
    chk("rf2_wr", mem_write_o, 0);
    chk("rf2_addr", mem_addr_o, 32'h0000_0800);
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("rf2_hold_en", mem_enable_o, 1);
      chk("rf2_hold_addr", mem_addr_o, 32'h0000_0800);
      chk("rf2_hold_stall", cpu_stall_o, 1);
    end
    mem_data_i = line2;
    mem_ack_i  = 1'b1;
    nxt();
    mem_ack_i = 1'b0;
    nxt();
    chk("ev_data", cpu_data_o, 32'hCAFE_F00D);
    chk("ev_stall_end", cpu_stall_o, 0);

    // read and write together: write wins, read shows old word
    cpu_MemWrite_i = 1'b1;
    cpu_data_i     = 32'h0BAD_C0DE;
    #1;
    chk("rw_old", cpu_data_o, 32'hCAFE_F00D);
    chk("rw_stall", cpu_stall_o, 0);
    nxt();
    cpu_MemWrite_i = 1'b0;
    #1;
    chk("rw_new", cpu_data_o, 32'h0BAD_C0DE);

    // reset in the middle of a writeback
    cpu_addr_i = 32'h0000_0404;
    #1;
    chk("r_miss", cpu_stall_o, 1);
    nxt();
    chk("r_wb_addr", mem_addr_o, 32'h0000_0800);
    chk("r_wb_w1", mem_data_o[63:32], 32'h0BAD_C0DE);
    rst_i = 1'b1;
    #1;
    chk("r_in_en", mem_enable_o, 0);
    nxt();
    rst_i = 1'b0;
    #1;
    chk("r_after_en", mem_enable_o, 0);
    chk("r_after_addr", mem_addr_o, 0);
    chk("r_reload_miss", cpu_stall_o, 1);
    nxt();
    chk("r_refill_en", mem_enable_o, 1);
    chk("r_refill_wr", mem_write_o, 0);
    chk("r_refill_addr", mem_addr_o, 32'h0000_0400);

    cpu_MemRead_i = 1'b0;
    rst_i         = 1'b1;
    nxt();
    rst_i = 1'b0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
